// File: rtl/stage_ex_mlane.sv
// Multi-cycle matrix execute lane unit.
// Forwards scalar and matrix operands at issue, latches them, then processes LPC lanes per cycle.
// The result is held on a valid/ready handshake; busy stalls ID/EX while an op is in flight.
module stage_ex_mlane #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned LANES = 4,
   parameter int unsigned LPC   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_mop,
   input  logic [XLEN-1:0]       in_op_a,
   input  logic [XLEN-1:0]       in_op_b,
   input  logic [LANES*XLEN-1:0] in_op_m,
   input  logic [1:0]            forward_a,
   input  logic [1:0]            forward_m,
   input  logic [XLEN-1:0]       me_alu_o,
   input  logic [XLEN-1:0]       w_regs_data,
   input  logic [LANES*XLEN-1:0] me_matrix_o,
   input  logic [LANES*XLEN-1:0] w_matrix_data,
   input  logic [1:0]            me_w_select,
   input  logic [1:0]            wb_w_select,
   input  logic [4:0]            me_rd,
   input  logic [4:0]            wb_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*XLEN-1:0] out_matrix,
   output logic [XLEN-1:0]       out_scalar,
   output logic                  out_is_matrix,
   output logic                  busy
);

   localparam int unsigned NBEAT = LANES / LPC;
   localparam int unsigned BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int unsigned LW    = $clog2(LANES);

   // Forwarding selects shared with the scalar pipeline.
   localparam logic [1:0] FwdExMem  = 2'b10;
   localparam logic [1:0] FwdMemWb  = 2'b01;
   localparam logic [1:0] SelScalar = 2'b10;
   localparam logic [2:0] MopMrsum  = 3'b110;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                  state_q, state_d;
   logic [BW-1:0]           beat_q, beat_d;
   logic [2:0]              mop_q, mop_d;
   logic [XLEN-1:0]         op_a_q, op_a_d;
   logic [LW-1:0]           op_b_q, op_b_d;
   logic [LANES*XLEN-1:0]   op_m_q, op_m_d;
   logic [LANES*XLEN-1:0]   res_q, res_d;
   logic [XLEN-1:0]         acc_q, acc_d;
   logic                    is_mat_q, is_mat_d;
   logic [XLEN-1:0]         fwd_a;
   logic [LANES*XLEN-1:0]   fwd_m;
   logic                    accept;
   logic                    last_beat;
   logic                    unused_op_b;

   // Only the lane-index bits of rs2 matter for MINS.
   assign unused_op_b = ^in_op_b[XLEN-1:LW];

   assign accept    = (state_q == StIdle) && in_valid && !flush;
   assign last_beat = (beat_q == BW'(NBEAT - 1));

   function automatic logic [XLEN-1:0] lane_op(input logic [2:0] mop, input logic [XLEN-1:0] m,
                                              input logic [XLEN-1:0] a, input logic hit);
      logic [XLEN-1:0] r;
      case (mop)
         3'b000:  r = m + a;
         3'b001:  r = m - a;
         3'b010:  r = m & a;
         3'b011:  r = m | a;
         3'b100:  r = m ^ a;
         3'b101:  r = a;
         3'b110:  r = m;
         default: r = hit ? a : m;
      endcase
      return r;
   endfunction

   // Operand forwarding; a scalar write in MEM/WB overrides only the lane it names.
   always_comb begin
      case (forward_a)
         FwdExMem: fwd_a = me_alu_o;
         FwdMemWb: fwd_a = w_regs_data;
         default:  fwd_a = in_op_a;
      endcase
      fwd_m = in_op_m;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (forward_m == FwdExMem) begin
            if (me_w_select == SelScalar) begin
               fwd_m[XLEN*i +: XLEN] = (me_rd == 5'(i)) ? me_alu_o : in_op_m[XLEN*i +: XLEN];
            end else begin
               fwd_m[XLEN*i +: XLEN] = me_matrix_o[XLEN*i +: XLEN];
            end
         end else if (forward_m == FwdMemWb) begin
            fwd_m[XLEN*i +: XLEN] = (wb_w_select == SelScalar && wb_rd == 5'(i)) ?
                                    w_regs_data : w_matrix_data[XLEN*i +: XLEN];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic; flush aborts from any state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StBusy;
         StBusy:  if (last_beat) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) state_d = StIdle;
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state_q == StIdle);
      busy      = (state_q != StIdle);
      out_valid = (state_q == StDone);
   end

   // Datapath next state: latch at accept, then one beat of lanes per BUSY cycle.
   always_comb begin
      int unsigned     idx;
      logic [XLEN-1:0] m;
      idx      = 0;
      m        = '0;
      beat_d   = beat_q;
      mop_d    = mop_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_m_d   = op_m_q;
      res_d    = res_q;
      acc_d    = acc_q;
      is_mat_d = is_mat_q;
      if (accept) begin
         beat_d   = '0;
         mop_d    = in_mop;
         op_a_d   = fwd_a;
         op_b_d   = in_op_b[LW-1:0];
         op_m_d   = fwd_m;
         acc_d    = '0;
         is_mat_d = (in_mop != MopMrsum);
      end else if (state_q == StBusy) begin
         for (int unsigned j = 0; j < LPC; j++) begin
            idx = LPC * 32'(beat_q) + j;
            m   = op_m_q[XLEN*idx +: XLEN];
            res_d[XLEN*idx +: XLEN] = lane_op(mop_q, m, op_a_q, op_b_q == LW'(idx));
            acc_d = acc_d + m;
         end
         beat_d = beat_q + 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q   <= '0;
         mop_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_m_q   <= '0;
         res_q    <= '0;
         acc_q    <= '0;
         is_mat_q <= 1'b0;
      end else begin
         beat_q   <= beat_d;
         mop_q    <= mop_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_m_q   <= op_m_d;
         res_q    <= res_d;
         acc_q    <= acc_d;
         is_mat_q <= is_mat_d;
      end
   end

   assign out_matrix    = res_q;
   assign out_scalar    = is_mat_q ? res_q[XLEN-1:0] : acc_q;
   assign out_is_matrix = is_mat_q;

endmodule

// File: tb/tb_stage_ex_mlane.sv
// Bench for stage_ex_mlane: two instances (LPC=1 and LPC=2) driven by shared stimulus,
// checked against a lane-array reference model.
module tb_stage_ex_mlane;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned LANES = 4;
   localparam int unsigned W     = XLEN * LANES;
   localparam logic [1:0]  FEX   = 2'b10;
   localparam logic [1:0]  FWB   = 2'b01;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [2:0]    in_mop;
   logic [31:0]   in_op_a, in_op_b, me_alu_o, w_regs_data;
   logic [W-1:0]  in_op_m, me_matrix_o, w_matrix_data;
   logic [1:0]    forward_a, forward_m, me_w_select, wb_w_select;
   logic [4:0]    me_rd, wb_rd;

   logic          r1_in_ready, r1_out_valid, r1_is_mat, r1_busy;
   logic [W-1:0]  r1_mat;
   logic [31:0]   r1_sc;
   logic          r2_in_ready, r2_out_valid, r2_is_mat, r2_busy;
   logic [W-1:0]  r2_mat;
   logic [31:0]   r2_sc;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [W-1:0]  exp_mat;
   logic [31:0]   exp_sc;
   logic          exp_ism;

   always #5 clk = ~clk;

   stage_ex_mlane #(.XLEN(XLEN), .LANES(LANES), .LPC(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1_in_ready),
      .in_mop(in_mop), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_m(in_op_m),
      .forward_a(forward_a), .forward_m(forward_m), .me_alu_o(me_alu_o),
      .w_regs_data(w_regs_data), .me_matrix_o(me_matrix_o), .w_matrix_data(w_matrix_data),
      .me_w_select(me_w_select), .wb_w_select(wb_w_select), .me_rd(me_rd), .wb_rd(wb_rd),
      .out_valid(r1_out_valid), .out_ready(out_ready), .out_matrix(r1_mat),
      .out_scalar(r1_sc), .out_is_matrix(r1_is_mat), .busy(r1_busy)
   );

   stage_ex_mlane #(.XLEN(XLEN), .LANES(LANES), .LPC(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r2_in_ready),
      .in_mop(in_mop), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_m(in_op_m),
      .forward_a(forward_a), .forward_m(forward_m), .me_alu_o(me_alu_o),
      .w_regs_data(w_regs_data), .me_matrix_o(me_matrix_o), .w_matrix_data(w_matrix_data),
      .me_w_select(me_w_select), .wb_w_select(wb_w_select), .me_rd(me_rd), .wb_rd(wb_rd),
      .out_valid(r2_out_valid), .out_ready(out_ready), .out_matrix(r2_mat),
      .out_scalar(r2_sc), .out_is_matrix(r2_is_mat), .busy(r2_busy)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: resolve operands from the current inputs, then apply the op lane by lane.
   task automatic model();
      logic [31:0] a, sum;
      logic [31:0] m[LANES];
      logic [31:0] r[LANES];
      a = (forward_a == FEX) ? me_alu_o : (forward_a == FWB) ? w_regs_data : in_op_a;
      sum = 0;
      for (int i = 0; i < LANES; i++) begin
         if (forward_m == FEX)
            m[i] = (me_w_select == 2'b10) ? ((me_rd == 5'(i)) ? me_alu_o : in_op_m[32*i +: 32])
                                          : me_matrix_o[32*i +: 32];
         else if (forward_m == FWB)
            m[i] = (wb_w_select == 2'b10 && wb_rd == 5'(i)) ? w_regs_data
                                                            : w_matrix_data[32*i +: 32];
         else
            m[i] = in_op_m[32*i +: 32];
         sum = sum + m[i];
         case (in_mop)
            3'd0: r[i] = m[i] + a;
            3'd1: r[i] = m[i] - a;
            3'd2: r[i] = m[i] & a;
            3'd3: r[i] = m[i] | a;
            3'd4: r[i] = m[i] ^ a;
            3'd5: r[i] = a;
            3'd6: r[i] = m[i];
            default: r[i] = (in_op_b[1:0] == 2'(i)) ? a : m[i];
         endcase
         exp_mat[32*i +: 32] = r[i];
      end
      exp_ism = (in_mop != 3'd6);
      exp_sc  = exp_ism ? r[0] : sum;
   endtask

   task automatic random_sources();
      me_alu_o      = $urandom;
      w_regs_data   = $urandom;
      me_matrix_o   = {$urandom, $urandom, $urandom, $urandom};
      w_matrix_data = {$urandom, $urandom, $urandom, $urandom};
      me_w_select   = 2'($urandom);
      wb_w_select   = 2'($urandom);
      me_rd         = 5'($urandom_range(0, 5));
      wb_rd         = 5'($urandom_range(0, 5));
   endtask

   // Issue one op, measure latency on both lanes, optionally hold in DONE, then handshake out.
   task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input logic [W-1:0] m, input logic [1:0] fa,
                         input logic [1:0] fm, input int hold);
      int lat1, lat2;
      in_mop = mop; in_op_a = a; in_op_b = b; in_op_m = m; forward_a = fa; forward_m = fm;
      model();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      // Operands are latched: disturb every input after the accept edge.
      in_op_a = $urandom; in_op_b = $urandom; in_op_m = {$urandom, $urandom, $urandom, $urandom};
      forward_a = 2'($urandom); forward_m = 2'($urandom); in_mop = 3'($urandom);
      random_sources();
      check({tag, "_rdy1"}, W'(r1_in_ready), W'(0));
      check({tag, "_busy1"}, W'(r1_busy), W'(1));
      check({tag, "_busy2"}, W'(r2_busy), W'(1));
      lat1 = 0; lat2 = 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (r1_out_valid && lat1 == 0) lat1 = c;
         if (r2_out_valid && lat2 == 0) lat2 = c;
      end
      check({tag, "_lat1"}, W'(lat1), W'(4));
      check({tag, "_lat2"}, W'(lat2), W'(2));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         tick();
         check({tag, "_hold_vld"}, W'(r1_out_valid), W'(1));
         check({tag, "_hold_mat"}, r1_mat, exp_mat);
         check({tag, "_hold_rdy"}, W'(r1_in_ready), W'(0));
      end
      check({tag, "_mat1"}, r1_mat, exp_mat);
      check({tag, "_mat2"}, r2_mat, exp_mat);
      check({tag, "_sc1"}, W'(r1_sc), W'(exp_sc));
      check({tag, "_sc2"}, W'(r2_sc), W'(exp_sc));
      check({tag, "_ism1"}, W'(r1_is_mat), W'(exp_ism));
      check({tag, "_ism2"}, W'(r2_is_mat), W'(exp_ism));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_post_vld"}, W'({r1_out_valid, r2_out_valid}), W'(0));
      check({tag, "_post_rdy"}, W'({r1_in_ready, r2_in_ready}), W'(2'b11));
   endtask

   initial begin
      logic seen_valid;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_mop = '0; in_op_a = '0; in_op_b = '0; in_op_m = '0;
      forward_a = '0; forward_m = '0;
      me_alu_o = '0; w_regs_data = '0; me_matrix_o = '0; w_matrix_data = '0;
      me_w_select = '0; wb_w_select = '0; me_rd = '0; wb_rd = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_rdy", W'({r1_in_ready, r2_in_ready}), W'(2'b11));
      check("rst_busy", W'({r1_busy, r2_busy}), W'(0));
      check("rst_vld", W'({r1_out_valid, r2_out_valid}), W'(0));
      check("rst_mat", r1_mat, W'(0));
      check("rst_sc", W'(r1_sc), W'(0));
      check("rst_ism", W'({r1_is_mat, r2_is_mat}), W'(0));

      run_op("t1_madd", 3'd0, 32'd10, 32'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 2'b00, 2'b00, 0);
      check("t1_lit", r1_mat, {32'd14, 32'd13, 32'd12, 32'd11});
      run_op("t2_mrsum", 3'd6, 32'd0, 32'd0, {32'hFFFFFFFF, 32'd1, 32'd2, 32'd3}, 2'b00, 2'b00, 0);
      check("t2_lit", W'(r1_sc), W'(5));

      me_w_select = 2'b10; me_rd = 5'd2; me_alu_o = 32'hAA;
      run_op("t3_fwd", 3'd3, 32'd0, 32'd0, {32'd7, 32'd6, 32'd5, 32'd4}, 2'b00, FEX, 0);
      check("t3_lit", r1_mat, {32'd7, 32'hAA, 32'd5, 32'd4});

      w_regs_data = 32'd77;
      run_op("t4_mins", 3'd7, 32'd55, 32'd3, {32'd9, 32'd8, 32'd7, 32'd6}, FWB, 2'b00, 0);
      check("t4_lit", r1_mat, {32'd77, 32'd8, 32'd7, 32'd6});

      random_sources();
      run_op("t5_hold", 3'd1, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom},
             2'($urandom), 2'($urandom), 5);

      // Flush during the second BUSY cycle (last beat for LPC=2).
      in_mop = 3'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t6_rdy", W'({r1_in_ready, r2_in_ready}), W'(2'b11));
      check("t6_busy", W'({r1_busy, r2_busy}), W'(0));
      seen_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         seen_valid = seen_valid | r1_out_valid | r2_out_valid;
      end
      check("t6_never_vld", W'(seen_valid), W'(0));
      run_op("t6_next", 3'd2, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom},
             2'b00, 2'b00, 0);

      // Flush in IDLE blocks the accept.
      in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check("fl_idle_busy", W'({r1_busy, r2_busy}), W'(0));

      // Reset mid-op returns to reset values.
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_rdy", W'({r1_in_ready, r2_in_ready}), W'(2'b11));
      check("rst_mid_mat", r1_mat | r2_mat, W'(0));
      check("rst_mid_ism", W'({r1_is_mat, r2_is_mat}), W'(0));

      for (int k = 0; k < 40; k++) begin
         random_sources();
         run_op("rnd", 3'($urandom), $urandom, $urandom,
                {$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 2'($urandom),
                int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
